// File: rtl/vec_mac_pkg.sv
// Shared types and helpers for the vector multiply-accumulate issue stage.
package vec_mac_pkg;

    typedef enum logic [2:0] {
        VMACC  = 3'b000,
        VNMSAC = 3'b010,
        VMADD  = 3'b100,
        VNMSUB = 3'b110
    } mac_op_e;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } mac_state_e;

    // Odd opcodes and the reserved element width are rejected.
    function automatic logic is_legal_mac(input logic [2:0] op, input logic [1:0] sew);
        return !op[0] && (sew != 2'b11);
    endfunction

endpackage

// File: rtl/vector_mac_issue_ctrl.sv
// Issues one multiply-accumulate request at a time to vector_multiply_add_unit and
// returns its result (or an error for illegal requests / lost completions) to writeback.
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module vector_mac_issue_ctrl
    import vec_mac_pkg::*;
#(
    parameter int unsigned VLEN           = `MAX_VLEN,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [1:0]      in_sew,
    input  logic            in_signed,
    input  logic [VLEN-1:0] in_a,
    input  logic [VLEN-1:0] in_b,
    input  logic [VLEN-1:0] in_c,
    output logic [VLEN-1:0] mac_data_A,
    output logic [VLEN-1:0] mac_data_B,
    output logic [VLEN-1:0] mac_data_C,
    output logic [2:0]      mac_accum_op,
    output logic [1:0]      mac_sew,
    output logic            mac_signed_mode,
    output logic            mac_Ctrl,
    output logic            mac_sew_16_32,
    output logic            mac_sew_32,
    output logic            mac_count_0,
    input  logic [VLEN-1:0] mac_result,
    input  logic            mac_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] out_data,
    output logic            out_err,
    output logic            busy
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    mac_state_e      state_q, state_d;
    logic [CntW-1:0] timeout_q;
    logic            legal;
    logic            accept;
    logic            timed_out;

    logic [VLEN-1:0] a_q, b_q, c_q, out_data_q;
    logic [2:0]      op_q;
    logic [1:0]      sew_q;
    logic            signed_q, ctrl_q, sew_16_32_q, sew_32_q, out_err_q;

    assign legal     = is_legal_mac(in_op, in_sew);
    assign accept    = in_valid && (state_q == IDLE);
    assign timed_out = (timeout_q == CntLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = legal ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mac_done || timed_out) state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= (state_q == WAIT) ? timeout_q + 1'b1 : '0;
        end
    end

    // Operand bank only reloads on a legal accept, so the unit inputs persist between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= '0;
            sew_q       <= '0;
            signed_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            sew_16_32_q <= 1'b0;
            sew_32_q    <= 1'b0;
        end else if (accept && legal) begin
            a_q         <= in_a;
            b_q         <= in_b;
            c_q         <= in_c;
            op_q        <= in_op;
            sew_q       <= in_sew;
            signed_q    <= in_signed;
            ctrl_q      <= in_op[1];
            sew_16_32_q <= (in_sew != 2'b00);
            sew_32_q    <= (in_sew == 2'b10);
        end
    end

    // Done takes priority over the timeout limit in the same WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else if (accept && !legal) begin
            out_data_q <= '0;
            out_err_q  <= 1'b1;
        end else if (state_q == WAIT) begin
            if (mac_done) begin
                out_data_q <= mac_result;
                out_err_q  <= 1'b0;
            end else if (timed_out) begin
                out_data_q <= '0;
                out_err_q  <= 1'b1;
            end
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid       = (state_q == RESP);
    assign busy            = (state_q != IDLE);
    assign mac_count_0     = (state_q == ISSUE);
    assign mac_data_A      = a_q;
    assign mac_data_B      = b_q;
    assign mac_data_C      = c_q;
    assign mac_accum_op    = op_q;
    assign mac_sew         = sew_q;
    assign mac_signed_mode = signed_q;
    assign mac_Ctrl        = ctrl_q;
    assign mac_sew_16_32   = sew_16_32_q;
    assign mac_sew_32      = sew_32_q;
    assign out_data        = out_data_q;
    assign out_err         = out_err_q;

endmodule

// File: tb/tb_vector_mac_issue_ctrl.sv
// Self-checking bench: table of directed requests, random requests against a reference
// model, and hand-written stale-done / reset-mid-WAIT sequences. A stub emulates the unit.
`timescale 1ns/1ps

module tb_vector_mac_issue_ctrl;

    localparam int unsigned VLEN = 64;
    localparam int unsigned TMO  = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, in_signed;
    logic [2:0]      in_op;
    logic [1:0]      in_sew;
    logic [VLEN-1:0] in_a, in_b, in_c;
    logic [VLEN-1:0] mac_data_A, mac_data_B, mac_data_C, mac_result, out_data;
    logic [2:0]      mac_accum_op;
    logic [1:0]      mac_sew;
    logic            mac_signed_mode, mac_Ctrl, mac_sew_16_32, mac_sew_32, mac_count_0;
    logic            mac_done, out_valid, out_ready, out_err, busy;

    always #5 clk = ~clk;

    vector_mac_issue_ctrl #(
        .VLEN           (VLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_sew          (in_sew),
        .in_signed       (in_signed),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_c            (in_c),
        .mac_data_A      (mac_data_A),
        .mac_data_B      (mac_data_B),
        .mac_data_C      (mac_data_C),
        .mac_accum_op    (mac_accum_op),
        .mac_sew         (mac_sew),
        .mac_signed_mode (mac_signed_mode),
        .mac_Ctrl        (mac_Ctrl),
        .mac_sew_16_32   (mac_sew_16_32),
        .mac_sew_32      (mac_sew_32),
        .mac_count_0     (mac_count_0),
        .mac_result      (mac_result),
        .mac_done        (mac_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_err         (out_err),
        .busy            (busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sew;
        logic        sgn;
        logic [63:0] a, b, c;
        int          delay;  // WAIT cycles before done; >= TMO means never
        int          stall;  // cycles out_ready stays low in RESP
        bit          stale;  // done held high from before accept through ISSUE
        logic        exp_err;
        logic [63:0] exp_data;
    } req_t;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [63:0] last_a = '0, last_b = '0, last_c = '0;
    logic [8:0]  last_ctrl = '0;
    req_t        tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference: element-0 arithmetic, 32-bit wrap, from the opcode table.
    function automatic logic [63:0] ref_mac(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] c);
        logic [31:0] x, y, z;
        x = a[31:0];
        y = b[31:0];
        z = c[31:0];
        case (op)
            3'b000:  return {32'b0, x * y + z};
            3'b010:  return {32'b0, z - x * y};
            3'b100:  return {32'b0, x * z + y};
            3'b110:  return {32'b0, y - x * z};
            default: return '0;
        endcase
    endfunction

    // Stand-in for the arithmetic unit, driven only by the issue stage's mac_* outputs.
    function automatic logic [63:0] unit_result();
        logic [31:0] p, s;
        p = mac_accum_op[2] ? mac_data_A[31:0] * mac_data_C[31:0]
                            : mac_data_A[31:0] * mac_data_B[31:0];
        s = mac_accum_op[2] ? mac_data_B[31:0] : mac_data_C[31:0];
        return {32'b0, mac_Ctrl ? s - p : s + p};
    endfunction

    function automatic req_t mk(input logic [2:0] op, input logic [1:0] sew, input logic sgn,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input int delay, input int stall,
                                input bit stale);
        req_t r;
        r.op    = op;
        r.sew   = sew;
        r.sgn   = sgn;
        r.a     = a;
        r.b     = b;
        r.c     = c;
        r.delay = delay;
        r.stall = stall;
        r.stale = stale;
        if (op[0] || sew == 2'b11 || delay >= int'(TMO)) begin
            r.exp_err  = 1'b1;
            r.exp_data = '0;
        end else begin
            r.exp_err  = 1'b0;
            r.exp_data = ref_mac(op, a, b, c);
        end
        return r;
    endfunction

    function automatic logic [8:0] ctrl_now();
        return {mac_accum_op, mac_sew, mac_signed_mode, mac_Ctrl, mac_sew_16_32, mac_sew_32};
    endfunction

    task automatic do_req(input req_t r);
        int   guard;
        int   waits;
        logic legal_r;
        logic [8:0] exp_ctrl;
        legal_r = !r.op[0] && (r.sew != 2'b11);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle_in_ready", in_ready, 1'b1);
        if (r.stale) begin
            mac_done   = 1'b1;
            mac_result = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        in_valid  = 1'b1;
        in_op     = r.op;
        in_sew    = r.sew;
        in_signed = r.sgn;
        in_a      = r.a;
        in_b      = r.b;
        in_c      = r.c;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_c     = {$urandom, $urandom};
        if (legal_r) begin
            exp_ctrl = {r.op, r.sew, r.sgn, r.op[1], r.sew != 2'b00, r.sew == 2'b10};
            check("issue_count0", mac_count_0, 1'b1);
            check("issue_valid", out_valid, 1'b0);
            check("mac_a", mac_data_A, r.a);
            check("mac_b", mac_data_B, r.b);
            check("mac_c", mac_data_C, r.c);
            check("mac_ctrl", ctrl_now(), exp_ctrl);
            last_a = r.a;
            last_b = r.b;
            last_c = r.c;
            last_ctrl = exp_ctrl;
            @(negedge clk);
            waits = 0;
            while (!out_valid && waits < 200) begin
                if (waits == r.delay) begin
                    mac_done   = 1'b1;
                    mac_result = unit_result();
                end else begin
                    mac_done   = 1'b0;
                    mac_result = {$urandom, $urandom};
                end
                @(negedge clk);
                waits++;
            end
            mac_done = 1'b0;
            check("latency", 64'(waits), (r.delay >= int'(TMO)) ? 64'(TMO) : 64'(r.delay + 1));
        end else begin
            mac_done = 1'b0;
            check("illegal_count0", mac_count_0, 1'b0);
            check("illegal_hold_a", mac_data_A, last_a);
            check("illegal_hold_ctrl", ctrl_now(), last_ctrl);
        end
        check("resp_valid", out_valid, 1'b1);
        check("resp_data", out_data, r.exp_data);
        check("resp_err", out_err, r.exp_err);
        for (int i = 0; i < r.stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, r.exp_data);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        req_t r;
        tbl[0] = mk(3'b000, 2'b10, 1'b0, 64'd5, 64'd3, 64'd2, 2, 0, 1'b0);
        tbl[1] = mk(3'b010, 2'b10, 1'b1, 64'd4, 64'd2, 64'd10, 0, 5, 1'b0);
        tbl[2] = mk(3'b100, 2'b01, 1'b0, 64'd6, 64'd3, 64'd2, 3, 0, 1'b0);
        tbl[3] = mk(3'b011, 2'b10, 1'b0, 64'd9, 64'd9, 64'd9, 0, 1, 1'b0);
        tbl[4] = mk(3'b000, 2'b11, 1'b0, 64'd1, 64'd2, 64'd3, 0, 0, 1'b0);
        tbl[5] = mk(3'b000, 2'b01, 1'b0, 64'd1, 64'd1, 64'd1, 1000, 0, 1'b0);
        tbl[6] = mk(3'b110, 2'b10, 1'b1, 64'd7, 64'd2, 64'd3, 1, 0, 1'b0);
        tbl[7] = mk(3'b000, 2'b00, 1'b0, 64'd2, 64'd3, 64'd4, 0, 0, 1'b1);

        reset = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_sew = '0;
        in_signed = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        mac_done = 1'b0;
        mac_result = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count0", mac_count_0, 1'b0);
        check("rst_out", {out_err, out_data}, '0);
        check("rst_mac_data", mac_data_A | mac_data_B | mac_data_C, '0);
        check("rst_mac_ctrl", ctrl_now(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_req(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [1:0] sew;
            op  = 3'($urandom_range(0, 7));
            sew = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                op[0] = 1'b0;
                sew   = 2'($urandom_range(0, 2));
            end
            r = mk(op, sew, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 6),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            do_req(r);
        end

        // Reset during WAIT, with a completion still pending after release.
        in_valid = 1'b1;
        in_op = 3'b000;
        in_sew = 2'b10;
        in_a = 64'd11;
        in_b = 64'd12;
        in_c = 64'd13;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_wait_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_count0", mac_count_0, 1'b0);
        check("mrst_out", {out_err, out_data}, '0);
        check("mrst_mac_data", mac_data_A | mac_data_B | mac_data_C, '0);
        check("mrst_mac_ctrl", ctrl_now(), '0);
        mac_done = 1'b1;
        mac_result = 64'h1234;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 1'b0);
            check("post_rst_in_ready", in_ready, 1'b1);
        end
        mac_done = 1'b0;
        last_a = '0;
        last_b = '0;
        last_c = '0;
        last_ctrl = '0;
        do_req(mk(3'b010, 2'b01, 1'b0, 64'd3, 64'd5, 64'd100, 2, 1, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
